// File: rtl/ahb_display_pkg.sv
// Shared types and constants for the AHB display slave: bus transfer codes,
// response FSM states, register indices and byte-lane helpers.
package ahb_display_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_DATA,
        RS_ERR1,
        RS_ERR2
    } resp_state_t;

    localparam logic [1:0] REG_DISP = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_LED  = 2'd2;
    localparam logic [1:0] REG_WCNT = 2'd3;

    localparam logic [6:0] BLANK_SEG      = 7'h7F;
    localparam int         CTRL_BLINK_BIT = 8;

    function automatic logic [31:0] low_ones(input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Expands HSIZE/HADDR[1:0] into a 32-bit write mask, one byte per lane.
    function automatic logic [31:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0]  lanes;
        logic [31:0] m;
        case (size)
            3'd0:    lanes = 4'b0001 << lo;
            3'd1:    lanes = lo[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{lanes[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (bit 0 = segment a).
module seg_hex_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = 7'h7F;
        case (nibble)
            4'h0: seg_n = 7'h40;
            4'h1: seg_n = 7'h79;
            4'h2: seg_n = 7'h24;
            4'h3: seg_n = 7'h30;
            4'h4: seg_n = 7'h19;
            4'h5: seg_n = 7'h12;
            4'h6: seg_n = 7'h02;
            4'h7: seg_n = 7'h78;
            4'h8: seg_n = 7'h00;
            4'h9: seg_n = 7'h10;
            4'hA: seg_n = 7'h08;
            4'hB: seg_n = 7'h03;
            4'hC: seg_n = 7'h46;
            4'hD: seg_n = 7'h21;
            4'hE: seg_n = 7'h06;
            4'hF: seg_n = 7'h0E;
        endcase
    end

endmodule

// File: rtl/ahb_display_slave.sv
// AHB-Lite slave owning the seven-segment digits and LED bank: register file,
// two-cycle ERROR response, hardware blink and registered segment outputs.
module ahb_display_slave
    import ahb_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int LED_WIDTH  = 18,
    parameter int BLINK_DIV  = 25000000,
    parameter int ADDR_WIDTH = 28
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [31:0]             HRDATA,
    output logic [NUM_DIGITS*7-1:0] hex_n,
    output logic [LED_WIDTH-1:0]    leds
);

    localparam logic [31:0] DISP_MASK = low_ones(4 * NUM_DIGITS);
    localparam logic [31:0] EN_MASK   = low_ones(NUM_DIGITS);
    localparam logic [31:0] CTRL_MASK = EN_MASK | (32'd1 << CTRL_BLINK_BIT);
    localparam logic [31:0] LED_MASK  = low_ones(LED_WIDTH);
    localparam int          PW        = $clog2(BLINK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(BLINK_DIV - 1);

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [31:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    htrans_t     trans;
    resp_state_t state;
    logic        accept, addr_err, wr_en;
    logic        write_p1;
    logic [1:0]  idx_p1;
    logic [31:0] mask_p1;
    logic [31:0] disp_r, ctrl_r, led_r;
    logic [15:0] wcnt_r;
    logic [PW-1:0] presc;
    logic        blink_phase, blink_en;
    logic [NUM_DIGITS*7-1:0] seg_dec;
    logic        unused_addr;

    assign trans       = htrans_t'(HTRANS);
    assign accept      = HSEL && HREADY && (trans == HT_NONSEQ || trans == HT_SEQ);
    assign addr_err    = (HWRITE && HADDR[3:2] == REG_WCNT) || (HSIZE > 3'd2)
                       || (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    assign unused_addr = ^HADDR[ADDR_WIDTH-1:4];

    // Address phase -> data phase: response FSM with registered HREADYOUT/HRESP
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= RS_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            write_p1  <= 1'b0;
            idx_p1    <= REG_DISP;
            mask_p1   <= '0;
        end else if (state == RS_ERR1) begin
            state     <= RS_ERR2;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b1;
        end else if (accept && addr_err) begin
            state     <= RS_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
        end else if (accept) begin
            state     <= RS_DATA;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            write_p1  <= HWRITE;
            idx_p1    <= HADDR[3:2];
            mask_p1   <= lane_mask(HSIZE, HADDR[1:0]);
        end else begin
            state     <= RS_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
        end
    end

    assign wr_en = (state == RS_DATA) && write_p1;

    // Data phase -> register file update at the edge closing the data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            disp_r <= '0;
            ctrl_r <= EN_MASK;
            led_r  <= '0;
            wcnt_r <= '0;
        end else if (wr_en) begin
            case (idx_p1)
                REG_DISP: disp_r <= merge_lanes(disp_r, HWDATA, mask_p1) & DISP_MASK;
                REG_CTRL: ctrl_r <= merge_lanes(ctrl_r, HWDATA, mask_p1) & CTRL_MASK;
                REG_LED:  led_r  <= merge_lanes(led_r,  HWDATA, mask_p1) & LED_MASK;
                default:  ;
            endcase
            wcnt_r <= wcnt_r + 16'd1;
        end
    end

    always_comb begin
        HRDATA = '0;
        if (state == RS_DATA && !write_p1) begin
            case (idx_p1)
                REG_DISP: HRDATA = disp_r;
                REG_CTRL: HRDATA = ctrl_r;
                REG_LED:  HRDATA = led_r;
                default:  HRDATA = {16'h0000, wcnt_r};
            endcase
        end
    end

    assign blink_en = ctrl_r[CTRL_BLINK_BIT];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            presc       <= '0;
            blink_phase <= 1'b0;
        end else if (!blink_en) begin
            presc       <= '0;
            blink_phase <= 1'b0;
        end else if (presc == PRESC_MAX) begin
            presc       <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            presc       <= presc + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg_hex_decode u_dec (
            .nibble (disp_r[4*g +: 4]),
            .seg_n  (seg_dec[7*g +: 7])
        );
    end

    // Register file -> pins: segments trail the register update by one cycle
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hex_n <= {NUM_DIGITS{7'h40}};
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_n[7*i +: 7] <= (!ctrl_r[i] || (blink_en && blink_phase)) ? BLANK_SEG
                                                                              : seg_dec[7*i +: 7];
            end
        end
    end

    assign leds = led_r[LED_WIDTH-1:0];

endmodule

// File: tb/tb_ahb_display_slave.sv
// Scoreboard bench for ahb_display_slave: pipelined AHB driver, read results
// queued at issue and compared in the data phase.
module tb_ahb_display_slave;

    localparam int ND = 8;
    localparam int LW = 18;
    localparam int BD = 4;
    localparam int AW = 28;

    logic            HCLK = 1'b0;
    logic            HRESETn = 1'b0;
    logic            HSEL = 1'b0;
    logic [AW-1:0]   HADDR = '0;
    logic [1:0]      HTRANS = 2'b00;
    logic            HWRITE = 1'b0;
    logic [2:0]      HSIZE = 3'd0;
    logic [31:0]     HWDATA = '0;
    logic            HREADY;
    logic            HREADYOUT;
    logic            HRESP;
    logic [31:0]     HRDATA;
    logic [ND*7-1:0] hex_n;
    logic [LW-1:0]   leds;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahb_display_slave #(
        .NUM_DIGITS (ND),
        .LED_WIDTH  (LW),
        .BLINK_DIV  (BD),
        .ADDR_WIDTH (AW)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .hex_n     (hex_n),
        .leds      (leds)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    bit          pend_rd = 1'b0;
    logic [31:0] pend_wd = '0;

    localparam logic [ND*7-1:0] HEX_ZERO = {ND{7'h40}};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [ND*7-1:0] exp_hex(input logic [31:0] disp, input logic [7:0] en,
                                                input bit blank);
        logic [ND*7-1:0] r;
        for (int i = 0; i < ND; i++) begin
            r[7*i +: 7] = (!en[i] || blank) ? 7'h7F : seg_of(disp[4*i +: 4]);
        end
        return r;
    endfunction

    // One bus cycle: new address phase plus the data phase of the previous transfer.
    task automatic drive(input logic [1:0] trans, input bit wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wd,
                         input string tag, input logic [31:0] exp);
        HSEL   = (trans != 2'b00);
        HTRANS = trans;
        HADDR  = addr[AW-1:0];
        HWRITE = wr;
        HSIZE  = size;
        HWDATA = pend_wd;
        if (trans[1] && !wr) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(negedge HCLK);
        check("okay_resp", {62'd0, HREADYOUT, HRESP}, 64'd2);
        if (pend_rd) check(tag_q.pop_front(), HRDATA, exp_q.pop_front());
        else         check("rdata_idle", HRDATA, 64'd0);
        pend_rd = trans[1] && !wr;
        pend_wd = wd;
        @(posedge HCLK); #1;
    endtask

    task automatic wr_x(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd);
        drive(2'b10, 1'b1, addr, size, wd, "", 32'd0);
    endtask

    task automatic rd_x(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        drive(2'b10, 1'b0, addr, 3'd2, 32'd0, tag, exp);
    endtask

    task automatic idle();
        drive(2'b00, 1'b0, 32'd0, 3'd0, 32'd0, "", 32'd0);
    endtask

    task automatic err_xfer(input string tag, input bit wr, input logic [31:0] addr,
                            input logic [2:0] size);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr[AW-1:0]; HWRITE = wr; HSIZE = size; HWDATA = '0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HWDATA = 32'hDEADBEEF;
        @(negedge HCLK);
        check({tag, "_c1"}, {62'd0, HREADYOUT, HRESP}, 64'd1);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        check({tag, "_c2"}, {62'd0, HREADYOUT, HRESP}, 64'd3);
        @(posedge HCLK); #1;
        pend_rd = 1'b0;
        pend_wd = '0;
    endtask

    // Writes CTRL, then samples n cycles starting from the first hex_n update.
    task automatic blink_run(input string tag, input logic [31:0] ctrl, input int n,
                             input logic [31:0] disp);
        bit blank;
        wr_x(32'h4, 3'd2, ctrl);
        idle();
        @(posedge HCLK);
        for (int k = 0; k < n; k++) begin
            @(negedge HCLK);
            blank = ctrl[8] && (((k / 4) % 2) == 1);
            check(tag, hex_n, exp_hex(disp, ctrl[7:0], blank));
        end
        @(posedge HCLK); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_hex", hex_n, HEX_ZERO);
        check("rst_leds", leds, 64'd0);
        check("rst_resp", {62'd0, HREADYOUT, HRESP}, 64'd2);
        check("rst_rdata", HRDATA, 64'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        rd_x("rst_ctrl", 32'h4, 32'h0000_00FF);
        rd_x("rst_wcnt", 32'hC, 32'h0);
        idle();

        wr_x(32'h0, 3'd2, 32'h89AB_CDEF);
        rd_x("disp_rbw", 32'h0, 32'h89AB_CDEF);
        check("hex_latency", hex_n, HEX_ZERO);
        idle();
        check("hex_disp", hex_n, exp_hex(32'h89AB_CDEF, 8'hFF, 1'b0));
        check("hex_dig0", hex_n[6:0], 64'h0E);
        check("hex_dig7", hex_n[55:49], 64'h00);
        rd_x("wcnt_1", 32'hC, 32'd1);

        wr_x(32'h9, 3'd0, 32'h0000_5A00);
        rd_x("led_byte", 32'h8, 32'h0000_5A00);
        idle();
        check("leds_byte", leds, 64'h05A00);
        wr_x(32'hA, 3'd1, 32'hFFFF_0000);
        rd_x("led_half", 32'h8, 32'h0003_5A00);
        idle();
        check("leds_half", leds, 64'h35A00);

        drive(2'b01, 1'b1, 32'h0, 3'd2, 32'h0BAD_0BAD, "", 32'd0);
        rd_x("busy_ignored", 32'h0, 32'h89AB_CDEF);
        wr_x(32'h3, 3'd0, 32'h1200_0000);
        rd_x("disp_byte3", 32'h0, 32'h12AB_CDEF);
        idle();

        err_xfer("err_wcnt_wr", 1'b1, 32'hC, 3'd2);
        err_xfer("err_misal_word", 1'b0, 32'h2, 3'd2);
        err_xfer("err_size3", 1'b0, 32'h0, 3'd3);
        err_xfer("err_misal_half", 1'b1, 32'h1, 3'd1);
        rd_x("wcnt_after_err", 32'hC, 32'd4);
        rd_x("disp_after_err", 32'h0, 32'h12AB_CDEF);
        idle();

        blink_run("blink_on", 32'h1F0, 16, 32'h12AB_CDEF);
        blink_run("blink_off", 32'h0F0, 10, 32'h12AB_CDEF);
        blink_run("blink_restart", 32'h1F0, 8, 32'h12AB_CDEF);
        blink_run("blink_off2", 32'h0F0, 2, 32'h12AB_CDEF);

        wr_x(32'h0, 3'd2, 32'h1111_1111);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h1111_1111;
        #2 HRESETn = 1'b0;
        #1;
        check("rst_mid_hex", hex_n, HEX_ZERO);
        check("rst_mid_leds", leds, 64'd0);
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        pend_rd = 1'b0;
        pend_wd = '0;
        @(posedge HCLK); #1;
        rd_x("rst_mid_disp", 32'h0, 32'h0);
        rd_x("rst_mid_ctrl", 32'h4, 32'h0000_00FF);
        rd_x("rst_mid_wcnt", 32'hC, 32'h0);
        idle();
        check("rst_mid_hex2", hex_n, HEX_ZERO);

        for (int i = 0; i < 65535; i++) begin
            wr_x(32'h8, 3'd2, i);
        end
        rd_x("wcnt_ffff", 32'hC, 32'h0000_FFFF);
        wr_x(32'h8, 3'd2, 32'hFFFF_FFFF);
        rd_x("wcnt_wrap", 32'hC, 32'h0);
        rd_x("led_full", 32'h8, 32'h0003_FFFF);
        idle();
        check("leds_full", leds, 64'h3FFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
